pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter BITS, default 9: width of the recovered duty value.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the period and high-time counters; legal range CNT_WIDTH >= BITS+2.
REQ-003 SHALL have port clk  input  1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port pwm_in  input  1: PWM waveform, asynchronous to clk.
REQ-006 SHALL have port period  output  CNT_WIDTH: last measured period in clk cycles.
REQ-007 SHALL have port high_time  output  CNT_WIDTH: last measured high time in clk cycles.
REQ-008 SHALL have port value  output  BITS: recovered duty value.
REQ-009 SHALL have port valid  output  1: single-cycle strobe; period, high_time and value are updated in the same cycle.
REQ-010 SHALL have port stuck  output  1: level; input has had no edge for 2^CNT_WIDTH-1 cycles.
REQ-011 SHALL have port overrun  output  1: single-cycle strobe; a measurement was dropped.

Function
REQ-012 SHALL pass pwm_in through a 2-flop synchronizer followed by one history flop; rise_det = sync & ~hist, fall_det = ~sync & hist.
REQ-013 SHALL implement measurement FSM states IDLE, HIGH, LOW. IDLE->HIGH on rise_det. HIGH->LOW on fall_det. LOW->HIGH on rise_det (closing edge).
REQ-014 SHALL set period counter to 1 on every rise_det and increment it each cycle otherwise; the high counter behaves identically but freezes on fall_det.
REQ-015 SHALL define period as the cycle distance between consecutive rise_det pulses, and high_time as the distance from rise_det to fall_det.
REQ-016 SHALL, on a closing edge with the divider idle, latch period and high_time into divider operands and start the divider in that cycle (cycle 0).
REQ-017 SHALL compute value = floor(high_time * 2^BITS / period) with a sequential restoring divider of one quotient bit per cycle; high_time < period always holds, so value < 2^BITS.
REQ-018 SHALL assert valid, and update period, high_time and value together, exactly BITS+2 cycles after cycle 0.
REQ-019 SHALL continue measuring the next period while the divider runs.
REQ-020 SHALL, on a closing edge with the divider busy, drop that measurement, pulse overrun, and leave the running division undisturbed.
REQ-021 SHALL not produce a valid from the first rise_det after IDLE; the first valid follows the second rise_det.
REQ-022 SHALL declare a stuck condition when, in HIGH or LOW, the active counter reaches 2^CNT_WIDTH-1 without the expected edge: set stuck=1 and enter IDLE.
REQ-023 SHALL, in the stuck-entry cycle, pulse valid with value = 2^BITS-1 if sync=1 or 0 if sync=0, holding period and high_time; any division in flight is aborted without valid.
REQ-024 SHALL hold stuck=1 until the next rise_det, then clear it.
REQ-025 SHALL never let counters wrap.
REQ-026 SHALL, when stuck entry coincides with divider completion, output the stuck result; the divider result is discarded.

Reset
REQ-027 SHALL, while rst=1, force period=0, high_time=0, value=0, valid=0, stuck=0, overrun=0, FSM=IDLE, divider idle, and synchronizer/history flops=0.
REQ-028 SHALL abort any in-flight division on reset; no valid after release until two new rise_det events.

Verification
REQ-029 SHALL cover: rst held 20 cycles with pwm_in toggling -> all outputs 0, no valid.
REQ-030 SHALL cover: period 512, high 128, BITS=9 -> valid once per period from the second rising edge; period=512, high_time=128, value=128; valid 11 cycles after the closing rise_det.
REQ-031 SHALL cover: period 3, high 1 -> period=3, high_time=1, value=170; overrun pulses on closing edges that arrive while the divider is busy.
REQ-032 SHALL cover: steady PWM then pwm_in held 0 -> 65535 cycles after last rise_det, stuck=1 with one valid, value=0; next rising edge -> stuck=0.
REQ-033 SHALL cover: pwm_in held 1 from IDLE after one rise_det -> stuck=1, value=511 with one valid.
REQ-034 SHALL cover: rst pulsed 3 cycles after the divider starts -> no valid, all outputs 0, next valid only after two further rising edges.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input and
// recovers the duty value with a one-bit-per-cycle restoring divider.
//
// state | meaning
// IDLE  | no reference rising edge yet (after reset or stuck)
// HIGH  | after a rising edge, waiting for the falling edge
// LOW   | after a falling edge, waiting for the closing rising edge
module pwm_capture #(
  parameter int BITS      = 9,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic [BITS-1:0]      value,
  output logic                 valid,
  output logic                 stuck,
  output logic                 overrun
);

  localparam int DCW = $clog2(BITS + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [DCW-1:0]       DIV_LOAD = DCW'(BITS);
  localparam logic [DCW-1:0]       DIV_ONE  = DCW'(1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t state_q, state_d;

  logic sync1, sync2, hist;
  logic rise_det, fall_det;
  logic closing, stuck_hit;

  logic [CNT_WIDTH-1:0] per_cnt, hi_cnt;

  logic                 div_busy;
  logic [DCW-1:0]       div_cnt;
  logic [CNT_WIDTH-1:0] div_p, div_h, rem, rem_next;
  logic [CNT_WIDTH:0]   rem_sh;
  logic                 rem_ge;
  logic [BITS-1:0]      quot;

  assign rise_det = sync2 & ~hist;
  assign fall_det = ~sync2 & hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // An edge arriving in the same cycle the counter tops out still counts.
  always_comb begin
    state_d   = state_q;
    closing   = 1'b0;
    stuck_hit = 1'b0;
    case (state_q)
      IDLE: if (rise_det) state_d = HIGH;
      HIGH: begin
        if (fall_det) state_d = LOW;
        else if (hi_cnt == CNT_MAX) begin
          state_d   = IDLE;
          stuck_hit = 1'b1;
        end
      end
      LOW: begin
        if (rise_det) begin
          state_d = HIGH;
          closing = 1'b1;
        end else if (per_cnt == CNT_MAX) begin
          state_d   = IDLE;
          stuck_hit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      if (rise_det)               per_cnt <= CNT_ONE;
      else if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_ONE;
      if (rise_det) hi_cnt <= CNT_ONE;
      else if (state_q == HIGH && !fall_det && hi_cnt != CNT_MAX)
        hi_cnt <= hi_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            stuck <= 1'b0;
    else if (stuck_hit) stuck <= 1'b1;
    else if (rise_det)  stuck <= 1'b0;
  end

  // Remainder stays below div_p, so one extra bit covers the shifted value.
  always_comb begin
    rem_sh   = {rem, 1'b0};
    rem_ge   = (rem_sh >= {1'b0, div_p});
    rem_next = rem_ge ? CNT_WIDTH'(rem_sh - {1'b0, div_p}) : rem_sh[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period    <= '0;
      high_time <= '0;
      value     <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      div_busy  <= 1'b0;
      div_cnt   <= '0;
      div_p     <= '0;
      div_h     <= '0;
      rem       <= '0;
      quot      <= '0;
    end else begin
      valid   <= 1'b0;
      overrun <= 1'b0;
      if (stuck_hit) begin
        div_busy <= 1'b0;
        valid    <= 1'b1;
        value    <= {BITS{sync2}};
      end else if (div_busy) begin
        if (div_cnt == '0) begin
          div_busy  <= 1'b0;
          valid     <= 1'b1;
          value     <= quot;
          period    <= div_p;
          high_time <= div_h;
        end else begin
          rem     <= rem_next;
          quot    <= {quot[BITS-2:0], rem_ge};
          div_cnt <= div_cnt - DIV_ONE;
        end
      end
      if (closing) begin
        if (div_busy) overrun <= 1'b1;
        else begin
          div_p    <= per_cnt;
          div_h    <= hi_cnt;
          rem      <= hi_cnt;
          quot     <= '0;
          div_cnt  <= DIV_LOAD;
          div_busy <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed PWM waveforms, expected results queued at
// each driven rising edge and compared when valid/overrun appear.
module tb_pwm_capture;

  localparam int BITS = 9;
  localparam int CW   = 12;
  localparam int MAXC = (1 << CW) - 1;
  localparam int LAT  = BITS + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pwm_in;
  logic [CW-1:0] period, high_time;
  logic [BITS-1:0] value;
  logic          valid, stuck, overrun;

  pwm_capture #(.BITS(BITS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .period(period), .high_time(high_time), .value(value),
    .valid(valid), .stuck(stuck), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {int cyc; int p; int h; int v;} exp_t;
  exp_t exp_q[$];
  int   ovr_q[$];

  bit cur = 1'b0, m_have_rise = 1'b0, m_have_fall = 1'b0;
  int m_last_rise = 0, m_last_fall = 0, m_div_free = 0, m_out_p = 0, m_out_h = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, expv);
    end
  endtask

  // Drive one cycle of pwm_in; rising edges close a measurement in the model.
  task automatic drive(input bit v);
    if (v && !cur) begin
      if (m_have_rise && m_have_fall) begin
        int p, h;
        p = cyc - m_last_rise;
        h = m_last_fall - m_last_rise;
        if (cyc >= m_div_free) begin
          exp_q.push_back('{cyc + LAT, p, h, (h << BITS) / p});
          m_div_free = cyc + BITS + 2;
          m_out_p = p;
          m_out_h = h;
        end else begin
          ovr_q.push_back(cyc + 3);
        end
      end
      m_have_rise = 1'b1;
      m_have_fall = 1'b0;
      m_last_rise = cyc;
    end else if (!v && cur) begin
      m_have_fall = 1'b1;
      m_last_fall = cyc;
    end
    cur = v;
    pwm_in = v;
    @(posedge clk); #1;
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < h; j++) drive(1'b1);
      for (int j = 0; j < p - h; j++) drive(1'b0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   oc;
    if (rst === 1'b1) begin
      chk("reset_outputs", {period, high_time, value, valid, stuck, overrun}, 64'd0);
    end else begin
      if (valid === 1'b1) begin
        chk("valid_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("valid_cycle", cyc, e.cyc);
          chk("valid_period", period, e.p);
          chk("valid_high_time", high_time, e.h);
          chk("valid_value", value, e.v);
        end
      end
      if (overrun === 1'b1) begin
        chk("overrun_expected", ovr_q.size() != 0, 1);
        if (ovr_q.size() != 0) begin
          oc = ovr_q.pop_front();
          chk("overrun_cycle", cyc, oc);
        end
      end
    end
  end

  initial begin
    int t, r, a;
    rst = 1'b1;
    pwm_in = 1'b0;
    @(posedge clk); #1;
    repeat (20) begin
      pwm_in = ~pwm_in;
      @(posedge clk); #1;
    end
    pwm_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) drive(1'b0);

    wave(512, 128, 4);
    wave(3, 1, 30);
    wave(40, 10, 4);

    // Input held low until the counter tops out.
    t = m_last_rise + 3 + MAXC;
    exp_q.push_back('{t, m_out_p, m_out_h, 0});
    while (cyc < t - 1) drive(1'b0);
    chk("stuck_before_low", stuck, 0);
    drive(1'b0);
    chk("stuck_set_low", stuck, 1);
    m_have_rise = 1'b0;
    m_have_fall = 1'b0;

    // Single rising edge from IDLE, then held high.
    r = cyc;
    drive(1'b1);
    drive(1'b1);
    chk("stuck_held_to_rise", stuck, 1);
    drive(1'b1);
    chk("stuck_cleared", stuck, 0);
    t = r + 3 + MAXC;
    exp_q.push_back('{t, m_out_p, m_out_h, (1 << BITS) - 1});
    while (cyc < t - 1) drive(1'b1);
    chk("stuck_before_high", stuck, 0);
    drive(1'b1);
    chk("stuck_set_high", stuck, 1);
    m_have_rise = 1'b0;
    m_have_fall = 1'b0;
    repeat (10) drive(1'b0);

    // Reset three cycles after a division starts.
    a = cyc;
    repeat (4) drive(1'b1);
    repeat (6) drive(1'b0);
    drive(1'b1);
    repeat (5) drive(1'b1);
    chk("abort_cycle_reached", cyc, a + 16);
    rst = 1'b1;
    exp_q.delete();
    m_have_rise = 1'b0;
    m_have_fall = 1'b0;
    m_div_free = 0;
    repeat (3) drive(1'b0);
    rst = 1'b0;
    repeat (3) drive(1'b0);
    wave(20, 7, 3);
    repeat (30) drive(1'b0);

    chk("valid_queue_empty", exp_q.size(), 0);
    chk("overrun_queue_empty", ovr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
